// File: rtl/i2s_playback_tx.sv
// i2s_playback_tx: I2S playback serializer driving bclk/pblrc/pbdat from a 256-mclk frame.
// Ports: mclk (sole clock, 256x fs), rst (sync active-high), en (start/stop at frame boundary),
//        sample_l/sample_r/sample_valid (source samples), sample_ready (one-mclk accept strobe at cnt=255),
//        bclk (mclk/4), pblrc (0=left, 1=right), pbdat (MSB-first I2S data), underrun_cnt (saturating).
// Option: define I2S_TX_UNDERRUN_HOLD_EN to retransmit the previous frame on underrun instead of silence.
module i2s_playback_tx #(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SAMPLE_BITS-1:0] sample_l,
  input  logic [SAMPLE_BITS-1:0] sample_r,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   bclk,
  output logic                   pblrc,
  output logic                   pbdat,
  output logic [7:0]             underrun_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic [7:0]             r_ucnt;
  logic [SAMPLE_BITS-1:0] r_buf_l;
  logic [SAMPLE_BITS-1:0] r_buf_r;
  logic                   r_pbdat;
  logic                   r_rdy;
  logic                   w_go;
  logic [7:0]             w_cnt_nxt;
  logic [4:0]             w_slot;
  logic [5:0]             w_idx;
  logic [SAMPLE_BITS-1:0] w_word;
  logic [SAMPLE_BITS-1:0] w_sh;
  logic                   w_bit;
  // The idle cycle in which en is seen already acts as cnt=0 of the first frame.
  assign w_go      = (r_state == RUN) || en;
  assign w_cnt_nxt = w_go ? r_cnt + 8'd1 : 8'd0;
  // pbdat is registered from the next count so it lines up with the visible cnt (left MSB at cnt=4).
  assign w_slot    = w_cnt_nxt[6:2];
  assign w_idx     = 6'(SAMPLE_BITS) - {1'b0, w_slot};
  assign w_word    = w_cnt_nxt[7] ? r_buf_r : r_buf_l;
  assign w_sh      = w_word >> w_idx;
  assign w_bit     = (w_slot != 5'd0) && ({1'b0, w_slot} <= 6'(SAMPLE_BITS)) && w_sh[0];
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ucnt  <= '0;
      r_buf_l <= '0;
      r_buf_r <= '0;
      r_pbdat <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= (r_state == IDLE) ? (en ? RUN : IDLE) : ((r_rdy && !en) ? IDLE : RUN);
      r_cnt   <= w_cnt_nxt;
      r_pbdat <= w_bit;
      r_rdy   <= (w_cnt_nxt == 8'hFF);
      // r_rdy is high exactly in the cnt=255 cycle of a running frame.
      if (r_rdy && sample_valid) begin
        r_buf_l <= sample_l;
        r_buf_r <= sample_r;
      end else if (r_rdy) begin
        r_ucnt <= r_ucnt + {7'd0, r_ucnt != 8'hFF};
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        r_buf_l <= r_buf_l;
        r_buf_r <= r_buf_r;
`else
        r_buf_l <= '0;
        r_buf_r <= '0;
`endif
      end
    end
  end
  assign bclk         = r_cnt[1];
  assign pblrc        = r_cnt[7];
  assign pbdat        = r_pbdat;
  assign sample_ready = r_rdy;
  assign underrun_cnt = r_ucnt;
endmodule
